spi_slave_param: RTL and testbench
==================================

# spi_slave_param

Parametrised SPI slave front-end for the single-port RAM subsystem. It deserialises MOSI frames of DATA_W+2 bits (2-bit command plus payload) into a parallel word with a one-cycle valid strobe, and serialises RAM read data back on MISO. Compared with the fixed-width slave it replaces, it adds a configurable data width, explicit read-pending tracking, error signalling, a tx_valid timeout and clean abort on SS_n deassertion. It sits between the SPI pins and the RAM controller, with SPI bit timing equal to the system clk.

## Interface
- DATA_W, 8: payload width; frame width W = DATA_W+2; rx_data width W.
- TX_TIMEOUT, 16: max cycles spent in WAIT_TX waiting for tx_valid (≥1).
- clk  in  1  system and SPI bit clock, all logic on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- SS_n  in  1  slave select, active-low; frame boundary.
- MOSI  in  1  serial data in, MSB first.
- tx_valid  in  1  tx_data is valid (single-cycle pulse or level).
- tx_data  in  DATA_W  RAM read data to send.
- MISO  out  1  serial data out, MSB first; 0 when not transmitting.
- rx_data  out  W  last received frame {cmd[1:0], payload}.
- rx_valid  out  1  one-cycle strobe, rx_data valid.
- rd_pend  out  1  read address accepted, read data not yet returned.
- err  out  1  one-cycle strobe on protocol error or timeout.

## Operation
- Commands (rx_data[W-1:W-2]): 00 write address, 01 write data, 10 read address, 11 read data.
- States: IDLE, RX, WAIT_TX, TX, DONE.
- IDLE: SS_n sampled low moves the FSM to RX. The MOSI bit sampled on that edge is not a data bit.
- RX: one MOSI bit is shifted in per cycle, MSB first, for W cycles. On the W-th edge, rx_data is loaded with the full word.
- At the W-th RX edge, the FSM decodes the command:
  - 00, 01: rx_valid pulses, go to DONE.
  - 10: rx_valid pulses, rd_pend set to 1, go to DONE.
  - 11 with rd_pend=1: rx_valid pulses, go to WAIT_TX.
  - 11 with rd_pend=0: err pulses, no rx_valid, rx_data is still updated, go to DONE.
- WAIT_TX:
  - tx_valid=1: tx_data is captured, MISO is driven with tx_data[DATA_W-1], go to TX.
  - TX_TIMEOUT cycles without tx_valid: err pulses, rd_pend is kept, go to DONE.
- TX: MISO presents the next bit each cycle, so the word occupies DATA_W consecutive cycles. On the last edge, MISO goes to 0, rd_pend is cleared, go to DONE.
- DONE: MOSI is ignored until SS_n goes high.
- Abort: SS_n sampled high in any non-IDLE state sends the FSM to IDLE on that edge.
  - Abort takes priority over every other transition, including the W-th RX edge.
  - The bit counter and timeout counter are cleared, MISO goes to 0.
  - No rx_valid and no err are raised; rd_pend is unchanged.
- tx_valid outside WAIT_TX is ignored.

## Timing
- Reset values: state IDLE, MISO 0, rx_data 0, rx_valid 0, rd_pend 0, err 0, all counters 0.
- All outputs are registered.
- rx_valid is high in the cycle immediately after the edge that samples the last frame bit, for exactly one cycle.
- rx_data holds its value until the next completed frame.
- MISO latency: the first bit appears in the cycle after tx_valid is sampled high in WAIT_TX.
- Frame length:
  - Minimum SS_n-low time for a write frame is 1+W cycles.
  - A read-data frame additionally needs the WAIT_TX time plus DATA_W cycles.
- Bit counter width: $clog2(W+1). Timeout counter width: $clog2(TX_TIMEOUT+1).
- Counters saturate, never wrap.
- err and rx_valid are never high in the same cycle.

## Structure
- Package spi_slave_pkg:
  - state enum (IDLE, RX, WAIT_TX, TX, DONE);
  - command localparams CMD_WR_ADDR=2'b00, CMD_WR_DATA=2'b01, CMD_RD_ADDR=2'b10, CMD_RD_DATA=2'b11.
- Sub-module spi_tx_serializer (parameter DATA_W):
  - load/shift interface with a done flag;
  - it owns the MISO register.
- FSM, RX shift register and counters live in the top module.

## Test plan
All scenarios use DATA_W=8, TX_TIMEOUT=16.
- Write address: SS_n low, MOSI 00_1010_0101 -> rx_data=10'h0A5, rx_valid high one cycle, rd_pend=0, err=0.
- Read address: MOSI 10_0000_0011 -> rx_data=10'h203, rx_valid pulse, rd_pend=1.
- Read data after the read address, MOSI 11_0000_0000, tx_valid with tx_data=8'hC3 three cycles after rx_valid -> MISO 1,1,0,0,0,0,1,1 on 8 consecutive cycles starting the cycle after tx_valid, then 0; rd_pend=0.
- Read data from reset (rd_pend=0) -> err pulse, rx_valid stays 0, MISO stays 0.
- Abort: SS_n high after 5 bits of 01_xxxx -> FSM in IDLE next cycle, no rx_valid; the next full frame 01_1111_0000 -> rx_data=10'h1F0.
- Timeout: read address, then read data with no tx_valid for 16 cycles -> err pulse, MISO stays 0, rd_pend stays 1; rst_n low for one cycle mid-TX -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/spi_slave_pkg.sv
// Shared types and constants for the parametrised SPI slave.
// Contents:
//   state_t      - slave FSM states
//   CMD_*        - 2-bit frame command codes, taken from the top two frame bits
package spi_slave_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RX,
        WAIT_TX,
        TX,
        DONE
    } state_t;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

endpackage

// File: rtl/spi_tx_serializer.sv
// MSB-first parallel-to-serial shifter that owns the MISO register.
// Ports:
//   clk, rst_n - clock, synchronous active-low reset
//   i_load     - capture i_data and present its MSB on the next cycle
//   i_shift    - present the next bit; after the last bit, drive 0
//   i_clear    - drop MISO to 0 and forget the word (abort)
//   i_data     - word to send
//   o_miso     - registered serial output
//   o_done     - the last bit is currently on o_miso (next shift ends the word)
module spi_tx_serializer #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic              i_shift,
    input  logic              i_clear,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_miso,
    output logic              o_done
);

    localparam int unsigned CntW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    logic [DATA_W-1:0] r_sh;
    logic [CntW-1:0]   r_cnt;   // bits still to present after the current one
    logic              r_miso;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sh   <= '0;
            r_cnt  <= '0;
            r_miso <= 1'b0;
        end else if (i_clear) begin
            r_cnt  <= '0;
            r_miso <= 1'b0;
        end else if (i_load) begin
            r_miso <= i_data[DATA_W-1];
            r_sh   <= i_data << 1;
            r_cnt  <= CntW'(DATA_W - 1);
        end else if (i_shift) begin
            if (r_cnt != '0) begin
                r_miso <= r_sh[DATA_W-1];
                r_sh   <= r_sh << 1;
                r_cnt  <= r_cnt - 1'b1;
            end else begin
                r_miso <= 1'b0;
            end
        end
    end

    assign o_miso = r_miso;
    assign o_done = (r_cnt == '0);

endmodule

// File: rtl/spi_slave_param.sv
// Parametrised SPI slave front-end for the RAM subsystem. Receives
// {cmd[1:0], payload[DATA_W-1:0]} frames on MOSI (MSB first) and, for
// read-data commands, returns tx_data on MISO once tx_valid arrives.
// Ports:
//   clk, rst_n - system/SPI bit clock, synchronous active-low reset
//   SS_n       - slave select (active low), frame boundary; high aborts
//   MOSI       - serial data in
//   tx_valid   - tx_data valid (only honoured while waiting for read data)
//   tx_data    - RAM read data to send
//   MISO       - serial data out, 0 when idle
//   rx_data    - last received frame
//   rx_valid   - one-cycle strobe, rx_data updated by a valid frame
//   rd_pend    - read address accepted, read data not yet returned
//   err        - one-cycle strobe: read data without pending read, or timeout
module spi_slave_param
    import spi_slave_pkg::*;
#(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned TX_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              SS_n,
    input  logic              MOSI,
    input  logic              tx_valid,
    input  logic [DATA_W-1:0] tx_data,
    output logic              MISO,
    output logic [DATA_W+1:0] rx_data,
    output logic              rx_valid,
    output logic              rd_pend,
    output logic              err
);

    localparam int unsigned W       = DATA_W + 2;
    localparam int unsigned BitCntW = $clog2(W + 1);
    localparam int unsigned ToCntW  = $clog2(TX_TIMEOUT + 1);

    state_t             r_state;
    logic [BitCntW-1:0] r_bit_cnt;
    logic [ToCntW-1:0]  r_to_cnt;
    logic [W-2:0]       r_shift;
    logic [W-1:0]       r_rx_data;
    logic               r_rx_valid;
    logic               r_rd_pend;
    logic               r_err;

    logic [W-1:0] w_frame;
    logic [1:0]   w_cmd;
    logic         w_abort;
    logic         w_ser_load;
    logic         w_ser_shift;
    logic         w_ser_done;
    logic         w_miso;

    // Frame as it stands including the bit sampled on this edge.
    assign w_frame     = {r_shift, MOSI};
    assign w_cmd       = w_frame[W-1:W-2];
    assign w_abort     = (r_state != IDLE) && SS_n;
    assign w_ser_load  = (r_state == WAIT_TX) && !SS_n && tx_valid;
    assign w_ser_shift = (r_state == TX) && !SS_n;

    spi_tx_serializer #(
        .DATA_W (DATA_W)
    ) u_tx (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_ser_load),
        .i_shift (w_ser_shift),
        .i_clear (w_abort),
        .i_data  (tx_data),
        .o_miso  (w_miso),
        .o_done  (w_ser_done)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_bit_cnt  <= '0;
            r_to_cnt   <= '0;
            r_shift    <= '0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_rd_pend  <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            r_err      <= 1'b0;
            if (w_abort) begin
                // Abort beats every other transition; rd_pend is left alone.
                r_state   <= IDLE;
                r_bit_cnt <= '0;
                r_to_cnt  <= '0;
            end else begin
                unique case (r_state)
                    IDLE: begin
                        if (!SS_n) begin
                            r_state   <= RX;
                            r_bit_cnt <= '0;
                            r_to_cnt  <= '0;
                        end
                    end
                    RX: begin
                        r_shift <= w_frame[W-2:0];
                        if (r_bit_cnt != BitCntW'(W)) begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                        if (r_bit_cnt == BitCntW'(W - 1)) begin
                            r_rx_data <= w_frame;
                            r_state   <= DONE;
                            unique case (w_cmd)
                                CMD_WR_ADDR, CMD_WR_DATA: r_rx_valid <= 1'b1;
                                CMD_RD_ADDR: begin
                                    r_rx_valid <= 1'b1;
                                    r_rd_pend  <= 1'b1;
                                end
                                CMD_RD_DATA: begin
                                    if (r_rd_pend) begin
                                        r_rx_valid <= 1'b1;
                                        r_to_cnt   <= '0;
                                        r_state    <= WAIT_TX;
                                    end else begin
                                        r_err <= 1'b1;
                                    end
                                end
                                default: r_state <= DONE;
                            endcase
                        end
                    end
                    WAIT_TX: begin
                        if (tx_valid) begin
                            r_state <= TX;
                        end else if (r_to_cnt >= ToCntW'(TX_TIMEOUT - 1)) begin
                            r_err   <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            r_to_cnt <= r_to_cnt + 1'b1;
                        end
                    end
                    TX: begin
                        if (w_ser_done) begin
                            r_rd_pend <= 1'b0;
                            r_state   <= DONE;
                        end
                    end
                    DONE: r_state <= DONE;
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign MISO     = w_miso;
    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;
    assign rd_pend  = r_rd_pend;
    assign err      = r_err;

endmodule

// File: tb/tb_spi_slave_param.sv
// Directed testbench for spi_slave_param (DATA_W=8, TX_TIMEOUT=16).
module tb_spi_slave_param;

    logic       clk;
    logic       rst_n;
    logic       SS_n;
    logic       MOSI;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       MISO;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic       rd_pend;
    logic       err;

    int total = 0;
    int bad   = 0;

    spi_slave_param #(
        .DATA_W     (8),
        .TX_TIMEOUT (16)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .SS_n     (SS_n),
        .MOSI     (MOSI),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .MISO     (MISO),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rd_pend  (rd_pend),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; outputs are then sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Select, spend the non-data select edge, then shift n frame bits MSB first.
    task automatic send(input logic [9:0] f, input int n);
        SS_n = 1'b0;
        MOSI = 1'b0;
        tick();
        for (int i = 0; i < n; i++) begin
            MOSI = f[9-i];
            tick();
        end
    endtask

    task automatic deselect();
        SS_n = 1'b1;
        MOSI = 1'b0;
        tick();
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_miso"}, 32'(MISO), 32'h0);
        chk({tag, "_rx_data"}, 32'(rx_data), 32'h0);
        chk({tag, "_rx_valid"}, 32'(rx_valid), 32'h0);
        chk({tag, "_rd_pend"}, 32'(rd_pend), 32'h0);
        chk({tag, "_err"}, 32'(err), 32'h0);
    endtask

    logic [7:0] exp_byte;

    initial begin
        rst_n    = 1'b0;
        SS_n     = 1'b1;
        MOSI     = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        tick();
        tick();
        chk_reset("reset");
        rst_n = 1'b1;
        tick();

        // Write address 00_1010_0101
        send(10'h0A5, 10);
        chk("wa_rx_valid", 32'(rx_valid), 32'h1);
        chk("wa_rx_data", 32'(rx_data), 32'h0A5);
        chk("wa_rd_pend", 32'(rd_pend), 32'h0);
        chk("wa_err", 32'(err), 32'h0);
        tick();
        chk("wa_rx_valid_one_cycle", 32'(rx_valid), 32'h0);
        chk("wa_rx_data_hold", 32'(rx_data), 32'h0A5);
        deselect();

        // Read address 10_0000_0011
        send(10'h203, 10);
        chk("ra_rx_valid", 32'(rx_valid), 32'h1);
        chk("ra_rx_data", 32'(rx_data), 32'h203);
        chk("ra_rd_pend", 32'(rd_pend), 32'h1);
        deselect();

        // Read data, tx_valid three cycles after rx_valid, tx_data=C3
        send(10'h300, 10);
        chk("rd_rx_valid", 32'(rx_valid), 32'h1);
        chk("rd_rx_data", 32'(rx_data), 32'h300);
        tick();
        tick();
        tick();
        chk("rd_miso_before", 32'(MISO), 32'h0);
        tx_data  = 8'hC3;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        exp_byte = 8'hC3;
        for (int i = 7; i >= 0; i--) begin
            chk($sformatf("rd_miso_bit%0d", i), 32'(MISO), 32'(exp_byte[i]));
            tick();
        end
        chk("rd_miso_after", 32'(MISO), 32'h0);
        chk("rd_rd_pend_clr", 32'(rd_pend), 32'h0);
        chk("rd_err", 32'(err), 32'h0);
        deselect();

        // Read data from reset: no pending read
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("nrd_rd_pend", 32'(rd_pend), 32'h0);
        send(10'h300, 10);
        chk("nrd_err", 32'(err), 32'h1);
        chk("nrd_rx_valid", 32'(rx_valid), 32'h0);
        chk("nrd_rx_data", 32'(rx_data), 32'h300);
        chk("nrd_miso", 32'(MISO), 32'h0);
        tick();
        chk("nrd_err_one_cycle", 32'(err), 32'h0);
        chk("nrd_miso_hold", 32'(MISO), 32'h0);
        deselect();

        // Abort after 5 bits of 01_xxxx, then a full 01_1111_0000 frame
        send(10'h1A0, 5);
        deselect();
        chk("ab_rx_valid", 32'(rx_valid), 32'h0);
        chk("ab_err", 32'(err), 32'h0);
        chk("ab_rx_data_hold", 32'(rx_data), 32'h300);
        send(10'h1F0, 10);
        chk("ab_next_rx_valid", 32'(rx_valid), 32'h1);
        chk("ab_next_rx_data", 32'(rx_data), 32'h1F0);
        deselect();

        // Abort on the W-th edge wins over frame completion
        send(10'h0FF, 9);
        SS_n = 1'b1;
        MOSI = 1'b1;
        tick();
        chk("abw_rx_valid", 32'(rx_valid), 32'h0);
        chk("abw_rx_data", 32'(rx_data), 32'h1F0);
        MOSI = 1'b0;
        tick();
        chk("abw_rx_valid_later", 32'(rx_valid), 32'h0);

        // Timeout: read address then read data with no tx_valid
        send(10'h203, 10);
        chk("to_ra_rd_pend", 32'(rd_pend), 32'h1);
        deselect();
        send(10'h300, 10);
        chk("to_rd_rx_valid", 32'(rx_valid), 32'h1);
        for (int i = 1; i <= 16; i++) begin
            tick();
            if (i < 16) chk($sformatf("to_wait_err_%0d", i), 32'(err), 32'h0);
        end
        chk("to_err", 32'(err), 32'h1);
        chk("to_rx_valid", 32'(rx_valid), 32'h0);
        chk("to_miso", 32'(MISO), 32'h0);
        chk("to_rd_pend_kept", 32'(rd_pend), 32'h1);
        tick();
        chk("to_err_one_cycle", 32'(err), 32'h0);
        deselect();

        // tx_valid outside WAIT_TX is ignored
        tx_data  = 8'hFF;
        tx_valid = 1'b1;
        tick();
        tick();
        chk("idle_txv_miso", 32'(MISO), 32'h0);
        tx_valid = 1'b0;

        // Reset in the middle of TX (rd_pend still set)
        send(10'h300, 10);
        chk("rst_rd_rx_valid", 32'(rx_valid), 32'h1);
        tx_data  = 8'hA5;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        chk("rst_tx_bit7", 32'(MISO), 32'h1);
        tick();
        chk("rst_tx_bit6", 32'(MISO), 32'h0);
        tick();
        chk("rst_tx_bit5", 32'(MISO), 32'h1);
        rst_n = 1'b0;
        tick();
        chk_reset("midtx_reset");
        rst_n = 1'b1;
        deselect();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
